// File: rtl/wide_add_pkg.sv
// Shared types and default sizing for the chunked wide adder sequencer.
package wide_add_pkg;

  localparam int unsigned DEF_CHUNK_W = 5;
  localparam int unsigned DEF_NCHUNKS = 4;
  localparam int unsigned DEF_ADD_LAT = 1;

  // Sequencer states: IDLE waits for a request, ISSUE presents a chunk,
  // WAIT covers the core latency, DONE is the one-cycle result pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/wide_add_sequencer.sv
// Wide adder sequencer: adds two CHUNK_W*NCHUNKS-bit operands by driving an
// external CHUNK_W-bit adder core one chunk at a time, LSB chunk first, with
// the carry of each chunk fed into the next.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              request, accepted only while not busy
//   op_a, op_b, cin    operands and carry-in, sampled on accept
//   busy               operation in progress
//   done               one-cycle pulse, sum/cout valid
//   sum, cout          result, held until overwritten by the next operation
//   add_a/add_b/add_cin  chunk operands presented to the adder core
//   add_s/add_cout       chunk result returned by the core, ADD_LAT cycles later
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int unsigned CHUNK_W = DEF_CHUNK_W,
  parameter int unsigned NCHUNKS = DEF_NCHUNKS,
  parameter int unsigned ADD_LAT = DEF_ADD_LAT,
  localparam int unsigned W = CHUNK_W * NCHUNKS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W-1:0]       op_a,
  input  logic [W-1:0]       op_b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [W-1:0]       sum,
  output logic               cout,
  output logic [CHUNK_W-1:0] add_a,
  output logic [CHUNK_W-1:0] add_b,
  output logic               add_cin,
  input  logic [CHUNK_W-1:0] add_s,
  input  logic               add_cout
);

  localparam int unsigned IDX_W  = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
  localparam int unsigned WCNT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NCHUNKS - 1);
  localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(ADD_LAT);

  state_t              state_q, state_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_n;
  logic [W-1:0]        a_q, a_n;
  logic [W-1:0]        b_q, b_n;
  logic                carry_q, carry_n;
  logic                busy_n, done_n;
  logic [W-1:0]        sum_n;
  logic                cout_n;
  logic [CHUNK_W-1:0]  add_a_n, add_b_n;
  logic                add_cin_n;
  logic                capture;
  int unsigned         chunk_off;

  // Next-state and next-register values; the core-facing outputs are derived
  // from the next operand/index/carry so they are registered alongside them.
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    wcnt_n    = wcnt_q;
    a_n       = a_q;
    b_n       = b_q;
    carry_n   = carry_q;
    sum_n     = sum;
    cout_n    = cout;
    capture   = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    add_a_n   = '0;
    add_b_n   = '0;
    add_cin_n = 1'b0;
    chunk_off = 0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_n = ISSUE;
          a_n     = op_a;
          b_n     = op_b;
          carry_n = cin;
          idx_n   = '0;
          wcnt_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE, WAIT: begin
        if (wcnt_q == LAST_WCNT) begin
          capture = 1'b1;
        end else begin
          wcnt_n  = wcnt_q + WCNT_W'(1);
          state_n = WAIT;
        end
      end
      default: state_n = IDLE;
    endcase

    // Core result for the current chunk is valid in the last wait cycle.
    if (capture) begin
      for (int k = 0; k < int'(NCHUNKS); k++) begin
        if (idx_q == IDX_W'(k)) begin
          sum_n[k*CHUNK_W +: CHUNK_W] = add_s;
        end
      end
      carry_n = add_cout;
      wcnt_n  = '0;
      if (idx_q == LAST_IDX) begin
        state_n = DONE;
        cout_n  = add_cout;
      end else begin
        idx_n   = idx_q + IDX_W'(1);
        state_n = ISSUE;
      end
    end

    busy_n = (state_n == ISSUE) || (state_n == WAIT);
    done_n = (state_n == DONE);

    if (busy_n) begin
      chunk_off = 32'(idx_n) * CHUNK_W;
      add_a_n   = CHUNK_W'(a_n >> chunk_off);
      add_b_n   = CHUNK_W'(b_n >> chunk_off);
      add_cin_n = carry_n;
    end
  end

  // State, counters, operand/result registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      wcnt_q  <= wcnt_n;
      a_q     <= a_n;
      b_q     <= b_n;
      carry_q <= carry_n;
      busy    <= busy_n;
      done    <= done_n;
      sum     <= sum_n;
      cout    <= cout_n;
      add_a   <= add_a_n;
      add_b   <= add_b_n;
      add_cin <= add_cin_n;
    end
  end

endmodule
